keyboard_op_decoder: RTL and testbench
======================================

Name: keyboard_op_decoder

Overview:
- Receives raw PS/2 keyboard frames and decodes the scancodes into 3-bit game operations.
- Offers each operation to Game_Player over the keyboard_ready / keyboard_data / keyboard_read_fin handshake.
- It is the producer end of the interface Game_Player consumes, and sits between the board PS/2 pins and the game logic.
- All logic runs in the game clock domain.

Parameters:
- FILTER_LEN, 4, number of consecutive equal samples needed to accept a new level on ps2_clock and ps2_data.
- TIMEOUT_CYCLES, 50000, clock cycles allowed between PS/2 falling edges before a partial frame is discarded.
- LOG2_TIMEOUT, 16, width of the timeout counter.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- ps2_clock  in  1  raw PS/2 clock line (asynchronous).
- ps2_data  in  1  raw PS/2 data line (asynchronous).
- keyboard_read_fin  in  1  from Game_Player; 1 = current operation consumed.
- keyboard_ready  out  1  1 = keyboard_data holds an unconsumed operation.
- keyboard_data  out  3  operation code: W=000, A=001, S=010, D=011, SPACE=100, Z=101.
- overrun  out  1  one-cycle pulse when a decoded operation is discarded.

Behaviour:
- Reset values: keyboard_ready=0, keyboard_data=3'b110 (NONE), overrun=0. Receiver is IDLE, break flag=0, extended flag=0, held key=none.
- Input conditioning:
  - Two-flop synchroniser on each PS/2 line, then a FILTER_LEN majority-free stable filter.
  - A falling edge is a filtered ps2_clock transition from 1 to 0.
- Receiver FSM, states IDLE, SHIFT, CHECK:
  - IDLE: on a falling edge with data=0 (start bit), go to SHIFT with bit count 0.
  - SHIFT: on each falling edge, capture ps2_data LSB-first. Order is 8 data bits, parity, stop. After 10 captures, go to CHECK.
  - CHECK, one cycle: frame is valid only if odd parity holds over data+parity and stop=1. Valid bytes go to the byte decoder; invalid frames are dropped silently. Always return to IDLE.
  - Start bit=1 in IDLE: ignore the edge.
- Timeout: the counter clears on every falling edge and increments in SHIFT. Reaching TIMEOUT_CYCLES-1 forces IDLE and drops the partial frame.
- Byte decoder:
  - 0xF0: set break flag.
  - 0xE0: set extended flag.
  - Any other byte is a code. The break flag and extended flag clear after any code.
  - Make codes, non-extended: 0x1D→W, 0x1C→A, 0x1B→S, 0x23→D, 0x29→SPACE, 0x1A→Z.
  - Unmapped codes are ignored.
- Held-key (typematic) suppression:
  - A mapped make code equal to the held key produces no operation.
  - Otherwise it becomes the held key and produces an operation.
  - A break of the held key clears the held key. A break of any other key changes nothing.
- Handshake:
  - A produced operation while keyboard_ready=0 and keyboard_read_fin=0 sets keyboard_data and keyboard_ready=1 on the next edge.
  - keyboard_ready stays 1 and keyboard_data stays stable until keyboard_read_fin=1 is sampled; ready clears on that edge.
  - No new ready while keyboard_read_fin=1, so Game_Player's registered fin must drop first. Any produced operation is discarded with overrun=1 while either:
    - keyboard_ready=1, or
    - keyboard_read_fin=1.
  - keyboard_data keeps its last value after ready clears.
- Simultaneous events:
  - Produce and acknowledge in the same cycle: the acknowledge wins and the new operation is discarded with an overrun pulse.
  - Timeout and falling edge in the same cycle: the falling edge wins.
- Reset mid-frame or mid-handshake: everything returns to reset values immediately and asynchronously. There is no pending state after release.

Optional Feature:
- KEYBOARD_ARROW_EN defined: extended make codes are mapped E0 75→W, E0 6B→A, E0 72→S, E0 74→D. They take part in held-key suppression as distinct keys from the letters.
- Not defined: every E0-prefixed code, make or break, is ignored and leaves the held key unchanged.

Test Plan:
- Frame for 0x1D with valid parity/stop, read_fin tied to follow ready one cycle later → ready=1, data=000 for exactly 2 cycles, then ready=0; overrun never asserted.
- Frames 0x29, 0x29, 0x29 (typematic), then F0 29, then 0x29 → exactly two operations of 100 delivered.
- Frame 0x1A with bad parity, then valid 0x1C → only operation 001 delivered.
- Frame 0x23 with read_fin held 0 (ready held), then valid 0x1B → ready stays 1, data stays 011, overrun pulses once. Release read_fin → ready clears; no later 010.
- 5 data bits of a frame, then idle > TIMEOUT_CYCLES, then full 0x1D frame → single operation 000; no corruption.
- E0 75: with KEYBOARD_ARROW_EN → operation 000; without it → no ready. Reset low mid-frame → all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/keyboard_op_decoder.sv
// PS/2 keyboard receiver and scancode-to-game-operation decoder with ready/read_fin handshake.
// Define KEYBOARD_ARROW_EN to also map the E0-prefixed arrow keys onto W/A/S/D.
module keyboard_op_decoder #(
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter int unsigned LOG2_TIMEOUT   = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_clock,
    input  logic       ps2_data,
    input  logic       keyboard_read_fin,
    output logic       keyboard_ready,
    output logic [2:0] keyboard_data,
    output logic       overrun
);

    localparam int unsigned FCW = $clog2(FILTER_LEN) + 1;

    typedef enum logic [1:0] {StIdle, StShift, StCheck} rx_state_e;

    logic [1:0]              clk_sync_q, dat_sync_q;
    logic                    clk_filt_q, dat_filt_q;
    logic [FCW-1:0]          clk_cnt_q, dat_cnt_q;
    logic                    fall_edge;

    rx_state_e               state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [9:0]              shreg_q, shreg_d;
    logic [LOG2_TIMEOUT-1:0] tcnt_q, tcnt_d;
    logic                    frame_ok;
    logic [7:0]              rx_byte;

    logic                    brk_q, brk_d, ext_q, ext_d;
    logic                    held_vld_q, held_vld_d, held_ext_q, held_ext_d;
    logic [2:0]              held_op_q, held_op_d;
    logic                    map_hit, held_match, produce;
    logic [2:0]              map_op;

    logic                    ready_q, ready_d, overrun_q, overrun_d;
    logic [2:0]              data_q, data_d;

    // Synchronise, then accept a new level only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_sync_q <= 2'b11;
            dat_sync_q <= 2'b11;
            clk_filt_q <= 1'b1;
            dat_filt_q <= 1'b1;
            clk_cnt_q  <= '0;
            dat_cnt_q  <= '0;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clock};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
            if (clk_sync_q[1] == clk_filt_q) begin
                clk_cnt_q <= '0;
            end else if (clk_cnt_q == FCW'(FILTER_LEN - 1)) begin
                clk_filt_q <= clk_sync_q[1];
                clk_cnt_q  <= '0;
            end else begin
                clk_cnt_q <= clk_cnt_q + 1'b1;
            end
            if (dat_sync_q[1] == dat_filt_q) begin
                dat_cnt_q <= '0;
            end else if (dat_cnt_q == FCW'(FILTER_LEN - 1)) begin
                dat_filt_q <= dat_sync_q[1];
                dat_cnt_q  <= '0;
            end else begin
                dat_cnt_q <= dat_cnt_q + 1'b1;
            end
        end
    end

    assign fall_edge = clk_filt_q & ~clk_sync_q[1] & (clk_cnt_q == FCW'(FILTER_LEN - 1));
    assign rx_byte   = shreg_q[7:0];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        tcnt_d    = tcnt_q;
        frame_ok  = 1'b0;
        unique case (state_q)
            StIdle: begin
                tcnt_d = '0;
                if (fall_edge && !dat_filt_q) begin
                    state_d   = StShift;
                    bit_cnt_d = '0;
                end
            end
            StShift: begin
                // A falling edge takes priority over an expiring timeout.
                if (fall_edge) begin
                    tcnt_d    = '0;
                    shreg_d   = {dat_filt_q, shreg_q[9:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd9) state_d = StCheck;
                end else if (tcnt_q == LOG2_TIMEOUT'(TIMEOUT_CYCLES - 1)) begin
                    state_d = StIdle;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StCheck: begin
                frame_ok = (^shreg_q[8:0]) & shreg_q[9];
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        map_hit = 1'b0;
        map_op  = 3'b000;
        if (!ext_q) begin
            case (rx_byte)
                8'h1D:   begin map_hit = 1'b1; map_op = 3'b000; end
                8'h1C:   begin map_hit = 1'b1; map_op = 3'b001; end
                8'h1B:   begin map_hit = 1'b1; map_op = 3'b010; end
                8'h23:   begin map_hit = 1'b1; map_op = 3'b011; end
                8'h29:   begin map_hit = 1'b1; map_op = 3'b100; end
                8'h1A:   begin map_hit = 1'b1; map_op = 3'b101; end
                default: ;
            endcase
        end
`ifdef KEYBOARD_ARROW_EN
        else begin
            case (rx_byte)
                8'h75:   begin map_hit = 1'b1; map_op = 3'b000; end
                8'h6B:   begin map_hit = 1'b1; map_op = 3'b001; end
                8'h72:   begin map_hit = 1'b1; map_op = 3'b010; end
                8'h74:   begin map_hit = 1'b1; map_op = 3'b011; end
                default: ;
            endcase
        end
`endif
    end

    // Arrow keys are held as distinct keys from the letters via held_ext.
    assign held_match = held_vld_q && (held_ext_q == ext_q) && (held_op_q == map_op);

    always_comb begin
        brk_d      = brk_q;
        ext_d      = ext_q;
        held_vld_d = held_vld_q;
        held_ext_d = held_ext_q;
        held_op_d  = held_op_q;
        produce    = 1'b0;
        if (frame_ok) begin
            if (rx_byte == 8'hF0) begin
                brk_d = 1'b1;
            end else if (rx_byte == 8'hE0) begin
                ext_d = 1'b1;
            end else begin
                brk_d = 1'b0;
                ext_d = 1'b0;
                if (map_hit) begin
                    if (brk_q) begin
                        if (held_match) held_vld_d = 1'b0;
                    end else if (!held_match) begin
                        held_vld_d = 1'b1;
                        held_ext_d = ext_q;
                        held_op_d  = map_op;
                        produce    = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        ready_d   = ready_q;
        data_d    = data_q;
        overrun_d = 1'b0;
        if (ready_q && keyboard_read_fin) ready_d = 1'b0;
        if (produce) begin
            if (!ready_q && !keyboard_read_fin) begin
                ready_d = 1'b1;
                data_d  = map_op;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            tcnt_q     <= '0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            held_vld_q <= 1'b0;
            held_ext_q <= 1'b0;
            held_op_q  <= 3'b000;
            ready_q    <= 1'b0;
            data_q     <= 3'b110;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            tcnt_q     <= tcnt_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            held_vld_q <= held_vld_d;
            held_ext_q <= held_ext_d;
            held_op_q  <= held_op_d;
            ready_q    <= ready_d;
            data_q     <= data_d;
            overrun_q  <= overrun_d;
        end
    end

    assign keyboard_ready = ready_q;
    assign keyboard_data  = data_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_keyboard_op_decoder.sv
// Directed bench for keyboard_op_decoder: serialises PS/2 frames, scoreboards delivered operations.
module tb_keyboard_op_decoder;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       ps2_clock = 1'b1;
    logic       ps2_data = 1'b1;
    logic       keyboard_read_fin;
    logic       keyboard_ready;
    logic [2:0] keyboard_data;
    logic       overrun;

    int         vectors = 0;
    int         miscompares = 0;
    logic [2:0] exp_q[$];
    int         delivered = 0;
    int         ovr_cnt = 0;
    int         run_len = 0;
    int         last_len = 0;
    bit         auto_ack = 1'b0;
    bit         manual_fin = 1'b0;
    int         d0, o0;

    keyboard_op_decoder #(
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(400),
        .LOG2_TIMEOUT  (16)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ps2_clock        (ps2_clock),
        .ps2_data         (ps2_data),
        .keyboard_read_fin(keyboard_read_fin),
        .keyboard_ready   (keyboard_ready),
        .keyboard_data    (keyboard_data),
        .overrun          (overrun)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Monitor plus Game_Player model: fin is a registered copy of ready, one cycle late.
    initial begin
        logic rdy_d1;
        logic prev_rdy;
        logic [2:0] e;
        rdy_d1 = 1'b0;
        prev_rdy = 1'b0;
        keyboard_read_fin = 1'b0;
        forever begin
            @(negedge clock);
            if (overrun === 1'b1) ovr_cnt++;
            if (keyboard_ready === 1'b1 && !prev_rdy) begin
                delivered++;
                run_len = 1;
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_op: observed data %0h expected no operation",
                           keyboard_data);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("op_data", {29'd0, keyboard_data}, {29'd0, e});
                end
            end else if (keyboard_ready === 1'b1) begin
                run_len++;
            end else if (prev_rdy) begin
                last_len = run_len;
            end
            prev_rdy = (keyboard_ready === 1'b1);
            keyboard_read_fin = auto_ack ? rdy_d1 : manual_fin;
            rdy_d1 = (keyboard_ready === 1'b1);
        end
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (20) @(negedge clock);
        ps2_clock = 1'b0;
        repeat (20) @(negedge clock);
        ps2_clock = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
        ps2_data = 1'b1;
        repeat (60) @(negedge clock);
    endtask

    initial begin
        repeat (4) @(negedge clock);
        check("rst_ready", {31'd0, keyboard_ready}, 32'd0);
        check("rst_data", {29'd0, keyboard_data}, 32'd6);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // Single W with auto-acknowledge: ready held exactly two cycles.
        auto_ack = 1'b1;
        d0 = delivered; o0 = ovr_cnt;
        exp_q.push_back(3'b000);
        send_frame(8'h1D, 1'b0, 11);
        check("w_count", delivered - d0, 32'd1);
        check("w_ready_len", last_len, 32'd2);
        check("w_no_overrun", ovr_cnt - o0, 32'd0);
        check("w_ready_low", {31'd0, keyboard_ready}, 32'd0);
        check("w_data_kept", {29'd0, keyboard_data}, 32'd0);

        // Typematic SPACE suppression and release.
        d0 = delivered;
        exp_q.push_back(3'b100);
        exp_q.push_back(3'b100);
        send_frame(8'h29, 1'b0, 11);
        send_frame(8'h29, 1'b0, 11);
        send_frame(8'h29, 1'b0, 11);
        send_frame(8'hF0, 1'b0, 11);
        send_frame(8'h29, 1'b0, 11);
        send_frame(8'h29, 1'b0, 11);
        check("space_count", delivered - d0, 32'd2);

        // Bad parity frame dropped.
        d0 = delivered;
        exp_q.push_back(3'b001);
        send_frame(8'h1A, 1'b1, 11);
        send_frame(8'h1C, 1'b0, 11);
        check("parity_count", delivered - d0, 32'd1);

        // Held ready: second operation overruns.
        auto_ack = 1'b0;
        repeat (4) @(negedge clock);
        d0 = delivered; o0 = ovr_cnt;
        exp_q.push_back(3'b011);
        send_frame(8'h23, 1'b0, 11);
        check("hold_ready", {31'd0, keyboard_ready}, 32'd1);
        check("hold_data", {29'd0, keyboard_data}, 32'd3);
        send_frame(8'h1B, 1'b0, 11);
        check("hold_ready2", {31'd0, keyboard_ready}, 32'd1);
        check("hold_data2", {29'd0, keyboard_data}, 32'd3);
        check("hold_overrun", ovr_cnt - o0, 32'd1);
        manual_fin = 1'b1;
        repeat (2) @(negedge clock);
        manual_fin = 1'b0;
        repeat (3) @(negedge clock);
        check("release_ready", {31'd0, keyboard_ready}, 32'd0);
        repeat (100) @(negedge clock);
        check("release_count", delivered - d0, 32'd1);

        // Partial frame abandoned by timeout, then a clean frame.
        auto_ack = 1'b1;
        d0 = delivered;
        exp_q.push_back(3'b000);
        send_frame(8'h1D, 1'b0, 6);
        repeat (600) @(negedge clock);
        send_frame(8'h1D, 1'b0, 11);
        check("timeout_count", delivered - d0, 32'd1);

        // Extended arrow up.
        d0 = delivered;
`ifdef KEYBOARD_ARROW_EN
        exp_q.push_back(3'b000);
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'h75, 1'b0, 11);
        check("arrow_count", delivered - d0, 32'd1);
`else
        send_frame(8'hE0, 1'b0, 11);
        send_frame(8'h75, 1'b0, 11);
        check("arrow_count", delivered - d0, 32'd0);
`endif

        // Reset mid-handshake and mid-frame.
        auto_ack = 1'b0;
        repeat (4) @(negedge clock);
        exp_q.push_back(3'b001);
        send_frame(8'h1C, 1'b0, 11);
        check("pre_rst_ready", {31'd0, keyboard_ready}, 32'd1);
        send_frame(8'h23, 1'b0, 4);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("async_rst_ready", {31'd0, keyboard_ready}, 32'd0);
        check("async_rst_data", {29'd0, keyboard_data}, 32'd6);
        check("async_rst_overrun", {31'd0, overrun}, 32'd0);
        repeat (5) @(negedge clock);
        reset = 1'b1;
        auto_ack = 1'b1;
        repeat (5) @(negedge clock);
        d0 = delivered;
        exp_q.push_back(3'b000);
        send_frame(8'h1D, 1'b0, 11);
        check("post_rst_count", delivered - d0, 32'd1);
        check("post_rst_data", {29'd0, keyboard_data}, 32'd0);

        check("sb_empty", exp_q.size(), 32'd0);
        check("total_overrun", ovr_cnt, 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
